// File: rtl/sprite_anim_ctrl.sv
// Beat-driven open/hold/close sequencer and horizontal bounce for the two-frame
// sprite renderer; every visible output updates only on the vertical-blank tick.
module sprite_anim_ctrl #(
  parameter int SCREEN_W        = 1280,
  parameter int SCREEN_H        = 720,
  parameter int SPRITE_W        = 256,
  parameter int SPRITE_H        = 512,
  parameter int Y_BASE          = 300,
  parameter int X_INIT          = 512,
  parameter int X_STEP          = 4,
  parameter int HOLD_FRAMES     = 6,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        beat_in,
  input  logic        enable_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        open_or_close_out,
  output logic        frame_tick_out
);

  localparam logic [1:0]  ST_CLOSED = 2'd0;
  localparam logic [1:0]  ST_OPEN   = 2'd1;
  localparam logic [1:0]  ST_COOL   = 2'd2;

  localparam logic [9:0]  V_TICK    = 10'(SCREEN_H);
  localparam logic [10:0] X_MAX     = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] X_START   = 11'(X_INIT);
  localparam logic [11:0] STEP_12   = 12'(X_STEP);
  localparam logic [10:0] STEP_11   = 11'(X_STEP);
  localparam logic [7:0]  HOLD_LD   = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]  COOL_LD   = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [9:0]  Y_OPEN    = 10'(Y_BASE);
  localparam logic [9:0]  Y_CLOSED  = 10'(Y_BASE - SPRITE_H / 2);

  logic        detect;
  logic        tick_p0;
  logic        beat_pending;
  logic        beat_eff;
  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [10:0] x_pos;
  logic        dir_left;
  logic [11:0] x_right;
  logic [10:0] x_left;

  assign detect   = (hcount_in == 11'd0) && (vcount_in == V_TICK);
  assign beat_eff = beat_pending | beat_in;
  assign x_right  = {1'b0, x_pos} + STEP_12;
  assign x_left   = x_pos - STEP_11;

  // Stage p0: registered frame tick; everything below acts on tick_p0
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_p0 <= 1'b0;
    end else begin
      tick_p0 <= detect;
    end
  end

  // A beat landing on the tick cycle is consumed by that tick, never carried over
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      beat_pending <= 1'b0;
    end else if (tick_p0) begin
      beat_pending <= 1'b0;
    end else if (beat_in) begin
      beat_pending <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_CLOSED;
      cnt   <= 8'd0;
    end else if (tick_p0) begin
      if (!enable_in) begin
        state <= ST_CLOSED;
        cnt   <= 8'd0;
      end else begin
        case (state)
          ST_CLOSED: begin
            if (beat_eff) begin
              state <= ST_OPEN;
              cnt   <= HOLD_LD;
            end
          end
          ST_OPEN: begin
            if (beat_eff) begin
              cnt <= HOLD_LD;
            end else if (cnt == 8'd0) begin
              state <= ST_COOL;
              cnt   <= COOL_LD;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          ST_COOL: begin
            if (cnt == 8'd0) begin
              state <= ST_CLOSED;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          default: begin
            state <= ST_CLOSED;
            cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

  // Limits clamp exactly so the sprite never leaves [0, SCREEN_W-SPRITE_W]
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_pos    <= X_START;
      dir_left <= 1'b0;
    end else if (tick_p0 && enable_in) begin
      if (!dir_left) begin
        if (x_right >= {1'b0, X_MAX}) begin
          x_pos    <= X_MAX;
          dir_left <= 1'b1;
        end else begin
          x_pos <= x_right[10:0];
        end
      end else begin
        if ({1'b0, x_pos} <= STEP_12) begin
          x_pos    <= 11'd0;
          dir_left <= 1'b0;
        end else begin
          x_pos <= x_left;
        end
      end
    end
  end

  assign frame_tick_out    = tick_p0;
  assign open_or_close_out = (state == ST_OPEN);
  assign y_out             = (state == ST_OPEN) ? Y_OPEN : Y_CLOSED;
  assign x_out             = x_pos;

endmodule
